// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the IF/MEM SRAM arbiter: FSM state and owner
// encodings, strobe levels, reset level and the wait-counter load helper.
package ram_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [2:0]        cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SU    = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ACK      = 3'd5
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    // SRAM strobes are active-low
    localparam logic RamEnable  = 1'b0;
    localparam logic RamDisable = 1'b1;

    localparam word_t ZeroWord = '0;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    // The counter reaches zero on the last wait cycle, so it loads wait-1.
    function automatic cnt_t wait_load(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Pipeline-side and SRAM-side signal bundle of the arbiter; the arbiter uses
// the slave modport, the pipeline/SRAM environment uses the master modport.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    logic  if_req_i;
    word_t if_addr_i;
    word_t if_data_o;
    logic  if_ack_o;
    logic  mem_re_i;
    logic  mem_we_i;
    word_t mem_addr_i;
    word_t mem_wdata_i;
    word_t mem_rdata_o;
    logic  mem_ack_o;
    logic  stall_req_o;
    word_t ram_addr_o;
    word_t ram_wdata_o;
    word_t ram_rdata_i;
    logic  ram_data_oe_o;
    logic  ram_ce_n_o;
    logic  ram_oe_n_o;
    logic  ram_we_n_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        output if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_req_o,
               ram_addr_o, ram_wdata_o, ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, ram_rdata_i,
        input  if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_req_o,
               ram_addr_o, ram_wdata_o, ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
    );

endinterface

// File: rtl/ram_arbiter_wait_cnt.sv
// Loadable 3-bit down-counter that saturates at zero; done is high while the
// count is zero. Shared by the read wait and the write pulse.
module ram_wait_cnt
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  cnt_t load_val_i,
    input  logic dec_i,
    output logic done_o
);

    cnt_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 16-bit SRAM between instruction fetch and load/store, MEM first.
// Optional one-entry fetch buffer enabled by defining ARB_IFETCH_BUF_EN.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 1
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);

    localparam cnt_t RD_LOAD = wait_load(RD_WAIT);
    localparam cnt_t WR_LOAD = wait_load(WR_WAIT);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    word_t  addr_q, addr_d;
    word_t  wdata_q, wdata_d;
    word_t  if_data_q, if_data_d;
    word_t  mem_rdata_q, mem_rdata_d;

    logic cnt_load, cnt_dec, cnt_done;
    cnt_t cnt_val;
    logic ce_n, oe_n, we_n, data_oe, if_ack, mem_ack;
    logic  buf_hit;
    word_t buf_data;

    ram_wait_cnt u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= ZeroWord;
            wdata_q     <= ZeroWord;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;
        ce_n        = RamDisable;
        oe_n        = RamDisable;
        we_n        = RamDisable;
        data_oe     = 1'b0;
        if_ack      = 1'b0;
        mem_ack     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write beats read, MEM beats IF; the address is frozen at grant.
                if (bus.mem_we_i) begin
                    state_d = ST_WR_SU;
                    owner_d = OWN_MEM;
                    addr_d  = bus.mem_addr_i;
                    wdata_d = bus.mem_wdata_i;
                end else if (bus.mem_re_i) begin
                    state_d  = ST_RD;
                    owner_d  = OWN_MEM;
                    addr_d   = bus.mem_addr_i;
                    cnt_load = 1'b1;
                    cnt_val  = RD_LOAD;
                end else if (bus.if_req_i) begin
                    owner_d = OWN_IF;
                    if (buf_hit) begin
                        state_d   = ST_ACK;
                        if_data_d = buf_data;
                    end else begin
                        state_d  = ST_RD;
                        addr_d   = bus.if_addr_i;
                        cnt_load = 1'b1;
                        cnt_val  = RD_LOAD;
                    end
                end
            end
            ST_RD: begin
                ce_n = RamEnable;
                oe_n = RamEnable;
                if (cnt_done) begin
                    state_d = ST_ACK;
                    if (owner_q == OWN_IF) begin
                        if_data_d = bus.ram_rdata_i;
                    end else begin
                        mem_rdata_d = bus.ram_rdata_i;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_SU: begin
                ce_n     = RamEnable;
                data_oe  = 1'b1;
                state_d  = ST_WR_PULSE;
                cnt_load = 1'b1;
                cnt_val  = WR_LOAD;
            end
            ST_WR_PULSE: begin
                ce_n    = RamEnable;
                we_n    = RamEnable;
                data_oe = 1'b1;
                if (cnt_done) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                ce_n    = RamEnable;
                data_oe = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if_ack  = (owner_q == OWN_IF);
                mem_ack = (owner_q == OWN_MEM);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ARB_IFETCH_BUF_EN
    logic  buf_valid_q, buf_valid_d;
    word_t buf_tag_q, buf_tag_d;
    word_t buf_data_q, buf_data_d;

    // Any write may alias the buffered fetch, so it drops the entry outright.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if (state_q == ST_WR_SU) begin
            buf_valid_d = 1'b0;
        end else if ((state_q == ST_RD) && cnt_done && (owner_q == OWN_IF)) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = bus.ram_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= ZeroWord;
            buf_data_q  <= ZeroWord;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign buf_hit  = buf_valid_q && (bus.if_addr_i == buf_tag_q);
    assign buf_data = buf_data_q;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = ZeroWord;
`endif

    assign bus.if_data_o     = if_data_q;
    assign bus.if_ack_o      = if_ack;
    assign bus.mem_rdata_o   = mem_rdata_q;
    assign bus.mem_ack_o     = mem_ack;
    assign bus.ram_addr_o    = addr_q;
    assign bus.ram_wdata_o   = wdata_q;
    assign bus.ram_data_oe_o = data_oe;
    assign bus.ram_ce_n_o    = ce_n;
    assign bus.ram_oe_n_o    = oe_n;
    assign bus.ram_we_n_o    = we_n;
    assign bus.stall_req_o   = (bus.if_req_i & ~if_ack) |
                               ((bus.mem_re_i | bus.mem_we_i) & ~mem_ack);

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 16-bit external SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences SRAM strobe timing through an FSM and returns registered data with one-cycle acks.
- Raises stall_req_o so the pipeline controller freezes PC/IF-ID (or MEM) while a requester waits.
- MEM has fixed priority over IF.

Parameters:
- RD_WAIT, 1: cycles the RAM is held in read (ce_n=0, oe_n=0) before data capture; legal range 1..7.
- WR_WAIT, 1: cycles we_n is held low per write; legal range 1..7.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  fetch request; held until if_ack_o.
- if_addr_i  in  16  fetch address.
- if_data_o  out  16  fetched instruction; valid when if_ack_o is high, held until the next IF capture.
- if_ack_o  out  1  one-cycle fetch completion.
- mem_re_i  in  1  load request; held until mem_ack_o.
- mem_we_i  in  1  store request; held until mem_ack_o.
- mem_addr_i  in  16  load/store address.
- mem_wdata_i  in  16  store data.
- mem_rdata_o  out  16  load data; valid when mem_ack_o is high.
- mem_ack_o  out  1  one-cycle load/store completion.
- stall_req_o  out  1  pipeline stall request.
- ram_addr_o  out  16  SRAM address.
- ram_wdata_o  out  16  SRAM write data.
- ram_rdata_i  in  16  SRAM read data.
- ram_data_oe_o  out  1  tri-state enable for the data bus.
- ram_ce_n_o  out  1  chip enable, active-low.
- ram_oe_n_o  out  1  output enable, active-low.
- ram_we_n_o  out  1  write enable, active-low.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ram_ce_n_o=ram_oe_n_o=ram_we_n_o=1; ram_data_oe_o=0.
  - ram_addr_o=ram_wdata_o=0; if_data_o=mem_rdata_o=0; both acks=0; wait counter=0.
  - An operation interrupted mid-cycle is abandoned; there is no resume.
- States: IDLE, RD, WR_SU, WR_PULSE, WR_HOLD, ACK. An owner register (IF/MEM) is latched at grant.
- IDLE grant, in priority order:
  - mem_we_i -> WR_SU.
  - mem_re_i -> RD (owner MEM).
  - if_req_i -> RD (owner IF).
  - mem_re_i and mem_we_i both high: the write wins.
  - At grant, the address (and wdata for writes) is latched. Later input changes are ignored until ACK.
- RD:
  - ce_n=0, oe_n=0, data_oe=0.
  - Stays RD_WAIT cycles. On the last cycle, ram_rdata_i is registered into the owner's data output; then -> ACK.
- Write sequence:
  - WR_SU: ce_n=0, data_oe=1, we_n=1 for 1 cycle.
  - WR_PULSE: we_n=0 for WR_WAIT cycles.
  - WR_HOLD: we_n=1, data still driven for 1 cycle; then -> ACK.
  - oe_n=1 throughout the write sequence.
- ACK:
  - Owner's ack=1 for exactly one cycle; all RAM strobes deasserted.
  - New requests are not sampled in ACK; the next state is always IDLE.
- Latency, request seen in IDLE at cycle 0:
  - Read ack at cycle RD_WAIT+1.
  - Write ack at cycle WR_WAIT+3.
  - A held request is re-granted no earlier than 2 cycles after its ack.
- stall_req_o (combinational) = (if_req_i & ~if_ack_o) | ((mem_re_i | mem_we_i) & ~mem_ack_o).
- Counter: 3-bit. Loads on entry to RD/WR_PULSE and saturates at 0; no wrap.
- IF starvation while MEM requests back-to-back is accepted by design.

Optional Feature:
- Macro: ARB_IFETCH_BUF_EN.
- With the macro defined:
  - A one-entry fetch buffer (tag, data, valid) holds the last IF read.
  - In IDLE, if only IF requests and if_addr_i equals the tag with valid=1, go directly IDLE->ACK with no RAM access; hit ack arrives at cycle 1.
  - Any MEM write clears valid at its WR_SU cycle.
  - Reset clears valid.
- Without the macro: no buffer; every fetch takes the RD path.

Decomposition:
- defines.v additions:
  - State encodings (3-bit).
  - Owner encoding.
  - RamEnable/RamDisable strobe levels.
  - ZeroWord.
  - Existing RstEnable/RstDisable.
- One sub-module, ram_wait_cnt: a loadable 3-bit down-counter with a done flag, shared by RD and WR_PULSE.

Test Plan:
1. Reset: rst=1 mid-read at RD cycle 1 -> ce_n/oe_n/we_n=1, data_oe=0, acks 0 in the same cycle; after release, state IDLE.
2. IF read: RD_WAIT=1, if_req_i=1, if_addr_i=0x0010, ram_rdata_i=0x4A0F -> ce_n=0/oe_n=0 at cycle 1, if_ack_o=1 with if_data_o=0x4A0F at cycle 2, stall_req_o=1 in cycles 0-1.
3. MEM write: mem_we_i=1, addr=0x8000, wdata=0x1234, WR_WAIT=1 -> WR_SU c1, we_n=0 only in c2, WR_HOLD c3 with data_oe=1, mem_ack_o at c4.
4. Contention: if_req_i and mem_re_i asserted the same cycle -> MEM served first (mem_ack_o at c2); IF granted after ACK and IDLE, if_ack_o at c5; stall_req_o high until each requester's ack.
5. Address change: if_addr_i changes 0x0010->0x0020 during RD -> ram_addr_o stays 0x0010, returned data is from 0x0010.
6. With ARB_IFETCH_BUF_EN, two fetches of 0x0010 -> second acks at cycle 1 with no ce_n pulse; after a MEM write to any address, the third fetch goes through RD.
